keypad_icnumber_entry: RTL
==========================

# keypad_icnumber_entry

Upstream front end of the IC tester. Scans a 4x4 matrix keypad, debounces it, and assembles the typed part number as 8 packed BCD digits on `ICNumber`. That bus feeds the IC number decoder and gate testing logic. Raises `icg` when the operator confirms with '#', which starts testing.

## Interface
- `SCAN_DIV`, default 50000: clk cycles each column is driven; minimum 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full-scan frames needed to accept a press or a release; range 1..15.
- `clk`, input, 1: single system clock; all logic is on its rising edge.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `row`, input, 4: keypad rows. Active-low with pull-ups; asynchronous to `clk`.
- `col`, output, 4: keypad column drive. Exactly one bit is low.
- `ICNumber`, output, 32: entered number as 8 BCD nibbles. The newest digit is in [3:0].
- `digit_count`, output, 4: number of digits entered, 0..8.
- `icg`, output, 1: level signal. High means the entered number is confirmed and testing may run.
- `key_valid`, output, 1: one-cycle pulse per accepted key press.
- `key_code`, output, 4: code of the last accepted key. Valid from `key_valid` onward.

## Operation
- **Key map (row r, col c, both 0..3):**
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: * 0 # D
- **key_code values:** digits 0..9 map to their own value; A=0xA, B=0xB, C=0xC, D=0xD, *=0xE, #=0xF.
- **Synchronizer:** `row` passes through a 2-flop synchronizer before any use.
- **Scan:**
  - A dwell counter runs 0..SCAN_DIV-1; a column index runs 0..3.
  - `col` = ~(1<<index).
  - On the last dwell cycle, the synchronized rows are sampled. If any bit is low, the column's hit is recorded; if several rows are low, the lowest row index wins.
  - The index then advances and wraps 3->0.
- **Frame:** one frame is 4 columns. The frame result is the first hit in column order 0..3, or "none".
- **Debounce FSM** (evaluated at each frame end):
  - IDLE:
    - frame = key K: cand=K, cnt=1, go to PRESS_WAIT.
    - If DEBOUNCE_SCANS=1, accept immediately and go to HELD.
  - PRESS_WAIT:
    - frame = cand: cnt++. When cnt reaches DEBOUNCE_SCANS, accept cand and go to HELD.
    - frame = other key: restart with the new cand, cnt=1.
    - frame = none: go to IDLE.
  - HELD:
    - frame = none: cnt=1, go to RELEASE_WAIT.
    - frame = any key: stay. No repeat while held; a different key while held is ignored.
  - RELEASE_WAIT:
    - frame = none: cnt++. When cnt reaches DEBOUNCE_SCANS, go to IDLE.
    - frame = any key: go back to HELD.
- **Accept:** pulse `key_valid`, load `key_code`, and apply the entry rules below.
- **Entry rules:**
  - Digit, digit_count<8: ICNumber={ICNumber[27:0],digit}; digit_count++; icg=0.
  - Digit, digit_count=8: ignored (no shift). `key_valid` still pulses.
  - '#': if digit_count>0, icg=1; if digit_count=0, no effect.
  - '*': ICNumber=0, digit_count=0, icg=0.
  - A-D: no entry effect.
- **icg release:** `icg` stays high until '*', a new accepted digit, or reset.

## Timing
- **Reset values** (on clk edge with rst_n=0, from the next cycle):
  - col=4'b1110, dwell=0, index=0, FSM IDLE, cnt=0, synchronizer flops=1.
  - ICNumber=0, digit_count=0, icg=0, key_valid=0, key_code=0.
- **Reset mid-operation:** a reset in any FSM state or mid-dwell discards the press in progress; no `key_valid` is emitted for it.
- **Sampling latency:** the sample at the last dwell cycle sees the pin level from 2 cycles earlier.
- **Frame length:** 4·SCAN_DIV cycles.
- **Accept latency:** `key_valid`, `key_code`, `ICNumber`, `digit_count` and `icg` all update on the clk edge following the frame-end evaluation. They are registered together and are coherent in the same cycle.
- **Minimum press to accept:** DEBOUNCE_SCANS complete frames with the key held.
- **Minimum release before re-accepting the same key:** DEBOUNCE_SCANS none-frames.
- **Throughput:** `key_valid` is never high on two consecutive cycles.

## Test plan
Bench parameters: SCAN_DIV=4, DEBOUNCE_SCANS=3. A frame is 16 cycles.
- **Reset:** hold rst_n=0 for 3 cycles, release -> col=1110, ICNumber=0, digit_count=0, icg=0, key_valid=0, and `col` rotates 1110->1101->1011->0111 every 4 cycles.
- **Entry and confirm:** press/release 7,4,0,8 then '#' (row/col model, 5 frames each) -> ICNumber=0x00007408, digit_count=4, icg=1; exactly 5 `key_valid` pulses.
- **Debounce:** bounce '5' for 2 frames, release, then hold 5 frames -> one `key_valid`, key_code=5, only after the 3rd stable frame. A 2-frame glitch alone yields no pulse.
- **Overflow, clear, confirm guard:**
  - Enter 9 digits 1..9 -> ICNumber=0x12345678, digit_count=8; the 9th press pulses `key_valid`, key_code=9, and nothing shifts.
  - Then '*' -> ICNumber=0, digit_count=0, icg=0.
  - Then '#' -> icg stays 0.
- **Multi-key and held:**
  - Press '2' and '8' together (both in col 1) -> key_code=2.
  - Hold '2' for 20 frames -> one pulse only.
  - Press 'A' -> key_valid=1, key_code=0xA, ICNumber unchanged.
- **Reset during PRESS_WAIT, and icg drop:**
  - Assert rst_n=0 after 2 frames of '3' -> no pulse, all outputs at reset values.
  - With icg=1, enter digit '1' -> icg=0, and the digit is appended.

Source files
------------

// File: rtl/keypad_icnumber_entry.sv
// Keypad front end for the IC tester: scans a 4x4 matrix, debounces whole-scan frames,
// and assembles the typed part number as packed BCD with a '#' confirm level (icg).
//
// state          | meaning
// S_IDLE         | no key held, waiting for a key frame
// S_PRESS_WAIT   | candidate key seen, counting identical frames
// S_HELD         | key accepted, waiting for a none frame
// S_RELEASE_WAIT | counting none frames before re-arming
module keypad_icnumber_entry #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [31:0] ICNumber,
  output logic [3:0]  digit_count,
  output logic        icg,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  localparam int            DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB        = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_RELEASE_WAIT
  } state_t;

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic          dwell_last;
  logic          frame_end;

  logic          col_hit;
  logic [1:0]    hit_row;
  logic [3:0]    cur_code;
  logic          frame_hit_v;
  logic [3:0]    frame_hit_code;
  logic          frame_key_v;
  logic [3:0]    frame_key;

  state_t        state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [3:0]    cand, cand_nx;
  logic          accept;

  logic [31:0]   icn_nx;
  logic [3:0]    dcount_nx;
  logic          icg_nx;
  logic          kv_nx;
  logic [3:0]    kc_nx;

  function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = 4'hE;
      4'hD: code = 4'h0;
      4'hE: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // row is asynchronous to clk
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
    end
  end

  assign dwell_last = (dwell == DWELL_LAST);
  assign frame_end  = dwell_last && (col_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dwell   <= '0;
      col_idx <= 2'd0;
    end else if (dwell_last) begin
      dwell   <= '0;
      col_idx <= col_idx + 2'd1;
    end else begin
      dwell   <= dwell + DW'(1);
    end
  end

  assign col = ~(4'b0001 << col_idx);

  always_comb begin
    col_hit = ~&row_s2;
    casez (row_s2)
      4'b???0: hit_row = 2'd0;
      4'b??01: hit_row = 2'd1;
      4'b?011: hit_row = 2'd2;
      default: hit_row = 2'd3;
    endcase
    cur_code = key_lookup(hit_row, col_idx);
  end

  // First hit in column order wins; the column-3 sample is folded in combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_hit_v    <= 1'b0;
      frame_hit_code <= 4'h0;
    end else if (dwell_last) begin
      if (col_idx == 2'd3) begin
        frame_hit_v <= 1'b0;
      end else if (!frame_hit_v && col_hit) begin
        frame_hit_v    <= 1'b1;
        frame_hit_code <= cur_code;
      end
    end
  end

  assign frame_key_v = frame_hit_v | col_hit;
  assign frame_key   = frame_hit_v ? frame_hit_code : cur_code;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      cand        <= 4'd0;
      ICNumber    <= 32'd0;
      digit_count <= 4'd0;
      icg         <= 1'b0;
      key_valid   <= 1'b0;
      key_code    <= 4'd0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      cand        <= cand_nx;
      ICNumber    <= icn_nx;
      digit_count <= dcount_nx;
      icg         <= icg_nx;
      key_valid   <= kv_nx;
      key_code    <= kc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    accept   = 1'b0;
    if (frame_end) begin
      case (state)
        S_IDLE: begin
          if (frame_key_v) begin
            cand_nx = frame_key;
            if (DEB == 4'd1) begin
              accept   = 1'b1;
              cnt_nx   = 4'd0;
              state_nx = S_HELD;
            end else begin
              cnt_nx   = 4'd1;
              state_nx = S_PRESS_WAIT;
            end
          end
        end
        S_PRESS_WAIT: begin
          if (!frame_key_v) begin
            cnt_nx   = 4'd0;
            state_nx = S_IDLE;
          end else if (frame_key == cand) begin
            cnt_nx = cnt + 4'd1;
            if (cnt_nx == DEB) begin
              accept   = 1'b1;
              state_nx = S_HELD;
            end
          end else begin
            cand_nx = frame_key;
            cnt_nx  = 4'd1;
          end
        end
        S_HELD: begin
          if (!frame_key_v) begin
            cnt_nx   = 4'd1;
            state_nx = (DEB == 4'd1) ? S_IDLE : S_RELEASE_WAIT;
          end
        end
        default: begin
          if (frame_key_v) begin
            state_nx = S_HELD;
          end else begin
            cnt_nx = cnt + 4'd1;
            if (cnt_nx == DEB) state_nx = S_IDLE;
          end
        end
      endcase
    end
  end

  // Entry rules; every output is registered together so they move in the same cycle.
  always_comb begin
    icn_nx    = ICNumber;
    dcount_nx = digit_count;
    icg_nx    = icg;
    kv_nx     = 1'b0;
    kc_nx     = key_code;
    if (accept) begin
      kv_nx = 1'b1;
      kc_nx = cand_nx;
      if (cand_nx <= 4'd9) begin
        if (digit_count < 4'd8) begin
          icn_nx    = {ICNumber[27:0], cand_nx};
          dcount_nx = digit_count + 4'd1;
          icg_nx    = 1'b0;
        end
      end else if (cand_nx == 4'hF) begin
        if (digit_count != 4'd0) icg_nx = 1'b1;
      end else if (cand_nx == 4'hE) begin
        icn_nx    = 32'd0;
        dcount_nx = 4'd0;
        icg_nx    = 1'b0;
      end
    end
  end

endmodule
